// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: one request in flight, response LATENCY edges after acceptance.
// Optional DMEM_ALIGN_CHK_EN: odd byte addresses complete with an err pulse and no array side effect.
module dmem_responder #(
   parameter int ADDR_W  = 13,
   parameter int LATENCY = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        wr,
   input  logic [15:0] addr,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   output logic        data_valid,
   output logic        wr_ack,
   output logic        busy
`ifdef DMEM_ALIGN_CHK_EN
   ,
   output logic        err
`endif
);

   // Handshake: a request is taken when enable=1 at an edge with state IDLE;
   // while busy=1 enable is ignored; exactly one of data_valid/wr_ack (or err)
   // pulses for one cycle at the completion edge, and busy falls at that edge.
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] WAIT = 1'b1;

   logic [0:0]        state;
   logic [3:0]        cnt;
   logic              wr_q;
   logic [ADDR_W-1:0] idx_q;
   logic [15:0]       data_q;
   logic              done;
   logic              bad;
   logic              unused_addr;

   logic [15:0] mem [2**ADDR_W];

   assign done        = (state == WAIT) && (cnt == 4'd0);
   assign unused_addr = ^addr;

`ifdef DMEM_ALIGN_CHK_EN
   logic odd_q;
   assign bad = odd_q;
`else
   assign bad = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         busy       <= 1'b0;
         data_valid <= 1'b0;
         wr_ack     <= 1'b0;
         data_out   <= 16'h0000;
         wr_q       <= 1'b0;
         idx_q      <= '0;
         data_q     <= 16'h0000;
`ifdef DMEM_ALIGN_CHK_EN
         odd_q      <= 1'b0;
         err        <= 1'b0;
`endif
      end else begin
         data_valid <= 1'b0;
         wr_ack     <= 1'b0;
`ifdef DMEM_ALIGN_CHK_EN
         err        <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (enable) begin
                  wr_q   <= wr;
                  idx_q  <= addr[ADDR_W:1];
                  data_q <= data_in;
`ifdef DMEM_ALIGN_CHK_EN
                  odd_q  <= addr[0];
`endif
                  cnt    <= 4'(LATENCY - 1);
                  state  <= WAIT;
                  busy   <= 1'b1;
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (bad) begin
`ifdef DMEM_ALIGN_CHK_EN
                     err <= 1'b1;
`endif
                  end else if (wr_q) begin
                     wr_ack <= 1'b1;
                  end else begin
                     data_valid <= 1'b1;
                     data_out   <= mem[idx_q];
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The array has no reset; a reset during WAIT drops the pending write.
   always_ff @(posedge clk) begin
      if (!rst && done && wr_q && !bad) begin
         mem[idx_q] <= data_q;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: LATENCY=4 and LATENCY=1 instances, one expected queue each.
module tb_dmem_responder;

   localparam int LAT0 = 4;
   localparam int LAT1 = 1;
   localparam int W    = 50;
   localparam logic [1:0] K_NONE = 2'd0;
   localparam logic [1:0] K_RD   = 2'd1;
   localparam logic [1:0] K_ACK  = 2'd2;
   localparam logic [1:0] K_ERR  = 2'd3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        en0, wr0, dv0, ack0, busy0, err0;
   logic [15:0] addr0, din0, dout0;
   logic        en1, wr1, dv1, ack1, busy1, err1;
   logic [15:0] addr1, din1, dout1;

   logic [31:0] cyc = 32'd0;
   always @(posedge clk) cyc <= cyc + 32'd1;

   int checks = 0;
   int errors = 0;

   // entry = {kind[1:0], data_out[15:0], negedge cycle tag[31:0]}
   logic [W-1:0] exp_q0[$];
   logic [W-1:0] exp_q1[$];

   dmem_responder #(.ADDR_W(13), .LATENCY(LAT0)) dut0 (
      .clk(clk), .rst(rst), .enable(en0), .wr(wr0), .addr(addr0), .data_in(din0),
      .data_out(dout0), .data_valid(dv0), .wr_ack(ack0), .busy(busy0)
`ifdef DMEM_ALIGN_CHK_EN
      , .err(err0)
`endif
   );

   dmem_responder #(.ADDR_W(13), .LATENCY(LAT1)) dut1 (
      .clk(clk), .rst(rst), .enable(en1), .wr(wr1), .addr(addr1), .data_in(din1),
      .data_out(dout1), .data_valid(dv1), .wr_ack(ack1), .busy(busy1)
`ifdef DMEM_ALIGN_CHK_EN
      , .err(err1)
`endif
   );

`ifndef DMEM_ALIGN_CHK_EN
   assign err0 = 1'b0;
   assign err1 = 1'b0;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [1:0] obs_kind(input logic dv, input logic ack, input logic er);
      case ({dv, ack, er})
         3'b100:  return K_RD;
         3'b010:  return K_ACK;
         3'b001:  return K_ERR;
         default: return K_NONE;
      endcase
   endfunction

   task automatic score(input string name, input logic [1:0] k, input logic [15:0] d,
                        input logic [W-1:0] e);
      check({name, " kind"}, 32'(k), 32'(e[49:48]));
      check({name, " data_out"}, 32'(d), 32'(e[47:32]));
      check({name, " cycle"}, cyc, e[31:0]);
   endtask

   always @(negedge clk) begin
      if (dv0 || ack0 || err0) begin
         if (exp_q0.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut0 unexpected: dv=%0b ack=%0b err=%0b expected none (cycle %0d)",
                     dv0, ack0, err0, cyc);
         end else begin
            score("dut0", obs_kind(dv0, ack0, err0), dout0, exp_q0.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (dv1 || ack1 || err1) begin
         if (exp_q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut1 unexpected: dv=%0b ack=%0b err=%0b expected none (cycle %0d)",
                     dv1, ack1, err1, cyc);
         end else begin
            score("dut1", obs_kind(dv1, ack1, err1), dout1, exp_q1.pop_front());
         end
      end
   end

   // Called just after a falling edge; presents a request for one cycle and checks busy rose.
   task automatic req(input int d, input logic w, input logic [15:0] a, input logic [15:0] din,
                      input logic [1:0] k, input logic [15:0] exp_d);
      logic [31:0] tag;
      if (d == 0) begin
         en0 = 1'b1; wr0 = w; addr0 = a; din0 = din;
         tag = cyc + 32'(LAT0) + 32'd1;
         if (k != K_NONE) exp_q0.push_back({k, exp_d, tag});
      end else begin
         en1 = 1'b1; wr1 = w; addr1 = a; din1 = din;
         tag = cyc + 32'(LAT1) + 32'd1;
         if (k != K_NONE) exp_q1.push_back({k, exp_d, tag});
      end
      @(negedge clk);
      en0 = 1'b0;
      en1 = 1'b0;
      check($sformatf("dut%0d busy after accept", d), 32'(d == 0 ? busy0 : busy1), 32'd1);
   endtask

   task automatic settle(input int d);
      repeat (d == 0 ? LAT0 : LAT1) @(negedge clk);
      check($sformatf("dut%0d busy after completion", d), 32'(d == 0 ? busy0 : busy1), 32'd0);
   endtask

   task automatic access(input int d, input logic w, input logic [15:0] a, input logic [15:0] din,
                         input logic [1:0] k, input logic [15:0] exp_d);
      req(d, w, a, din, k, exp_d);
      settle(d);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      en0 = 1'b0; wr0 = 1'b0; addr0 = 16'h0; din0 = 16'h0;
      en1 = 1'b0; wr1 = 1'b0; addr1 = 16'h0; din1 = 16'h0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset busy0", 32'(busy0), 32'd0);
      check("reset data_valid0", 32'(dv0), 32'd0);
      check("reset wr_ack0", 32'(ack0), 32'd0);
      check("reset data_out0", 32'(dout0), 32'h0);
      check("reset busy1", 32'(busy1), 32'd0);
      check("reset data_out1", 32'(dout1), 32'h0);

      // Write then read the same word.
      access(0, 1'b1, 16'h0010, 16'h1234, K_ACK, 16'h0000);
      access(0, 1'b0, 16'h0010, 16'h0000, K_RD,  16'h1234);

      // Requests presented while busy are ignored.
      access(0, 1'b1, 16'h0020, 16'h5555, K_ACK, 16'h1234);
      req(0, 1'b0, 16'h0020, 16'h0000, K_RD, 16'h5555);
      en0 = 1'b1; wr0 = 1'b1; addr0 = 16'h0020; din0 = 16'hBEEF;
      repeat (3) @(negedge clk);
      en0 = 1'b0;
      repeat (LAT0 - 3) @(negedge clk);
      check("busy0 after ignored writes", 32'(busy0), 32'd0);
      access(0, 1'b0, 16'h0020, 16'h0000, K_RD, 16'h5555);

      // Reset in the middle of a write drops it.
      access(0, 1'b1, 16'h0030, 16'h1111, K_ACK, 16'h5555);
      req(0, 1'b1, 16'h0030, 16'h2222, K_NONE, 16'h0000);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid-write reset busy0", 32'(busy0), 32'd0);
      check("mid-write reset data_valid0", 32'(dv0), 32'd0);
      check("mid-write reset wr_ack0", 32'(ack0), 32'd0);
      check("mid-write reset data_out0", 32'(dout0), 32'h0);
      access(0, 1'b0, 16'h0030, 16'h0000, K_RD, 16'h1111);

      // Reset wins over a simultaneous enable.
      rst = 1'b1; en0 = 1'b1; wr0 = 1'b0; addr0 = 16'h0010;
      @(negedge clk);
      rst = 1'b0; en0 = 1'b0;
      check("rst+enable busy0", 32'(busy0), 32'd0);
      check("rst+enable data_out0", 32'(dout0), 32'h0);
      repeat (LAT0 + 1) @(negedge clk);
      check("rst+enable busy0 later", 32'(busy0), 32'd0);

      // Aliasing through bit 0 and bits above ADDR_W.
      access(0, 1'b1, 16'h4010, 16'hA5A5, K_ACK, 16'h0000);
      access(0, 1'b0, 16'h0010, 16'h0000, K_RD,  16'hA5A5);
`ifdef DMEM_ALIGN_CHK_EN
      access(0, 1'b0, 16'h0011, 16'h0000, K_ERR, 16'hA5A5);
`else
      access(0, 1'b0, 16'h0011, 16'h0000, K_RD,  16'hA5A5);
`endif

      // Top word of the array.
      access(0, 1'b1, 16'hFFFE, 16'hFFFF, K_ACK, 16'hA5A5);
      access(0, 1'b0, 16'h3FFE, 16'h0000, K_RD,  16'hFFFF);

`ifdef DMEM_ALIGN_CHK_EN
      access(0, 1'b1, 16'h0040, 16'h3C3C, K_ACK, 16'hFFFF);
      access(0, 1'b1, 16'h0041, 16'h7777, K_ERR, 16'hFFFF);
      access(0, 1'b0, 16'h0040, 16'h0000, K_RD,  16'h3C3C);
`endif

      // LATENCY=1 instance: response one edge after acceptance, busy for one cycle.
      access(1, 1'b1, 16'h0002, 16'h0BAD, K_ACK, 16'h0000);
      access(1, 1'b0, 16'h0002, 16'h0000, K_RD,  16'h0BAD);
      access(1, 1'b0, 16'h0003, 16'h0000,
`ifdef DMEM_ALIGN_CHK_EN
             K_ERR,
`else
             K_RD,
`endif
             16'h0BAD);

      repeat (LAT0 + 2) @(negedge clk);
      while (exp_q0.size() != 0) begin
         logic [W-1:0] e;
         e = exp_q0.pop_front();
         checks++;
         errors++;
         $display("FAIL dut0 missing response: got none expected kind %0d data %0h at cycle %0d",
                  e[49:48], e[47:32], e[31:0]);
      end
      while (exp_q1.size() != 0) begin
         logic [W-1:0] e;
         e = exp_q1.pop_front();
         checks++;
         errors++;
         $display("FAIL dut1 missing response: got none expected kind %0d data %0h at cycle %0d",
                  e[49:48], e[47:32], e[31:0]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
